// File: rtl/traffic_pkg.sv
// Shared traffic-light definitions: phase encodings, legal lamp codes and monitor FSM states.
// Lamp codes are packed as {green, amber, red}.
package traffic_pkg;

   typedef enum logic [1:0] {
      PH_RED       = 2'd0,
      PH_RED_AMBER = 2'd1,
      PH_GREEN     = 2'd2,
      PH_AMBER     = 2'd3
   } phase_t;

   typedef enum logic {
      ST_SYNC  = 1'b0,
      ST_TRACK = 1'b1
   } state_t;

   localparam logic [2:0] CODE_RED       = 3'b001;
   localparam logic [2:0] CODE_RED_AMBER = 3'b011;
   localparam logic [2:0] CODE_GREEN     = 3'b100;
   localparam logic [2:0] CODE_AMBER     = 3'b010;

   function automatic logic is_legal(input logic [2:0] code);
      return (code == CODE_RED) || (code == CODE_RED_AMBER) ||
             (code == CODE_GREEN) || (code == CODE_AMBER);
   endfunction

   function automatic phase_t code_to_phase(input logic [2:0] code);
      case (code)
         CODE_RED_AMBER: return PH_RED_AMBER;
         CODE_GREEN:     return PH_GREEN;
         CODE_AMBER:     return PH_AMBER;
         default:        return PH_RED;
      endcase
   endfunction

   function automatic phase_t next_phase(input phase_t p);
      case (p)
         PH_RED:       return PH_RED_AMBER;
         PH_RED_AMBER: return PH_GREEN;
         PH_GREEN:     return PH_AMBER;
         default:      return PH_RED;
      endcase
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts consecutive cycles a phase is held; 'over' flags a hold that would push
// the count past MAX_DWELL. The count saturates so a stuck lamp cannot wrap it.
module dwell_timer #(
   parameter int MAX_DWELL = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic hold,
   output logic over
);

   localparam int W = $clog2(MAX_DWELL + 2);
   localparam logic [W-1:0] ONE   = W'(1);
   localparam logic [W-1:0] LIMIT = W'(MAX_DWELL);
   localparam logic [W-1:0] SAT   = '1;

   logic [W-1:0] count;

   assign over = hold && !restart && (count >= LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (restart) begin
         count <= ONE;
      end else if (hold && (count != SAT)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/traffic_monitor.sv
// Watches a traffic-light controller's lamps, tracks the phase sequence and raises
// sticky flags for illegal lamp codes, out-of-order phases and over-long dwells.
module traffic_monitor
   import traffic_pkg::*;
#(
   parameter int MAX_DWELL = 16,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             red,
   input  logic             amber,
   input  logic             green,
   input  logic             clear,
   output logic             locked,
   output logic [1:0]       phase,
   output logic [CNT_W-1:0] cycle_count,
   output logic             code_err,
   output logic             seq_err,
   output logic             dwell_err,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [2:0] code;
   logic       legal;
   phase_t     code_phase;

   state_t state_q, state_d;
   phase_t phase_q, phase_d;
   logic   restart, hold, over;
   logic   code_ev, seq_ev, wrap_ev;
   logic   code_err_d, seq_err_d, dwell_err_d;

   assign code       = {green, amber, red};
   assign legal      = is_legal(code);
   assign code_phase = code_to_phase(code);

   dwell_timer #(.MAX_DWELL(MAX_DWELL)) u_dwell (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .hold    (hold),
      .over    (over)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      restart = 1'b0;
      hold    = 1'b0;
      code_ev = 1'b0;
      seq_ev  = 1'b0;
      wrap_ev = 1'b0;

      if (!legal) begin
         code_ev = 1'b1;
         state_d = ST_SYNC;
      end else if (state_q == ST_SYNC) begin
         phase_d = code_phase;
         state_d = ST_TRACK;
         restart = 1'b1;
      end else if (code_phase == phase_q) begin
         hold = 1'b1;
      end else begin
         // Both an orderly step and an out-of-order jump resynchronise to the new phase.
         phase_d = code_phase;
         restart = 1'b1;
         if (code_phase == next_phase(phase_q)) begin
            wrap_ev = (phase_q == PH_AMBER);
         end else begin
            seq_ev = 1'b1;
         end
      end

      // A new event outranks a coincident clear.
      code_err_d  = code_ev | (code_err  & ~clear);
      seq_err_d   = seq_ev  | (seq_err   & ~clear);
      dwell_err_d = over    | (dwell_err & ~clear);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_SYNC;
         phase_q     <= PH_RED;
         cycle_count <= '0;
         code_err    <= 1'b0;
         seq_err     <= 1'b0;
         dwell_err   <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         code_err  <= code_err_d;
         seq_err   <= seq_err_d;
         dwell_err <= dwell_err_d;
         err       <= code_err_d | seq_err_d | dwell_err_d;
         if (wrap_ev) begin
            cycle_count <= clear ? CNT_ONE : cycle_count + CNT_ONE;
         end else if (clear) begin
            cycle_count <= '0;
         end
      end
   end

   assign locked = (state_q == ST_TRACK);
   assign phase  = phase_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: a default instance and a CNT_W=2 instance
// share one stimulus stream; expected values are hand-computed constants.
module tb_traffic_monitor;

   logic       clk;
   logic       rst_n;
   logic       red, amber, green, clear;

   logic       locked, code_err, seq_err, dwell_err, err;
   logic [1:0] phase;
   logic [7:0] cycle_count;

   logic       locked2, code_err2, seq_err2, dwell_err2, err2;
   logic [1:0] phase2;
   logic [1:0] cycle_count2;

   int n_tests = 0;
   int n_fail  = 0;

   traffic_monitor u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .red         (red),
      .amber       (amber),
      .green       (green),
      .clear       (clear),
      .locked      (locked),
      .phase       (phase),
      .cycle_count (cycle_count),
      .code_err    (code_err),
      .seq_err     (seq_err),
      .dwell_err   (dwell_err),
      .err         (err)
   );

   traffic_monitor #(.CNT_W(2)) u_dut_w2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .red         (red),
      .amber       (amber),
      .green       (green),
      .clear       (clear),
      .locked      (locked2),
      .phase       (phase2),
      .cycle_count (cycle_count2),
      .code_err    (code_err2),
      .seq_err     (seq_err2),
      .dwell_err   (dwell_err2),
      .err         (err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Apply one lamp code for one cycle, then sample 1 time unit after the edge.
   task automatic step(input logic [2:0] code, input logic clr = 1'b0);
      {green, amber, red} = code;
      clear = clr;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   logic [2:0] seq [4];

   initial begin
      seq[0] = 3'b001;
      seq[1] = 3'b011;
      seq[2] = 3'b100;
      seq[3] = 3'b010;

      rst_n = 1'b0;
      {green, amber, red} = 3'b000;
      clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_locked", locked, 0);
      check("rst_phase", phase, 0);
      check("rst_count", cycle_count, 0);
      check("rst_err", {code_err, seq_err, dwell_err, err}, 0);
      rst_n = 1'b1;

      // Three clean sequences, one cycle per phase.
      for (int rep = 0; rep < 3; rep++) begin
         for (int i = 0; i < 4; i++) begin
            step(seq[i]);
            check($sformatf("seq_locked_%0d_%0d", rep, i), locked, 1);
            check($sformatf("seq_phase_%0d_%0d", rep, i), phase, i);
            check($sformatf("seq_err_%0d_%0d", rep, i), err, 0);
         end
      end
      check("seq_count", cycle_count, 2);
      check("seq_count_w2", cycle_count2, 2);

      // Illegal code mid-GREEN, then resync on RED without a sequence error.
      step(3'b001);
      check("pre_ill_count", cycle_count, 3);
      step(3'b011);
      step(3'b100);
      step(3'b000);
      check("ill_code_err", code_err, 1);
      check("ill_locked", locked, 0);
      check("ill_phase_hold", phase, 2);
      check("ill_seq_err", seq_err, 0);
      step(3'b001);
      check("resync_locked", locked, 1);
      check("resync_seq_err", seq_err, 0);
      check("resync_code_sticky", code_err, 1);
      check("resync_phase", phase, 0);
      step(3'b001, 1'b1);
      check("clr_flags", {code_err, seq_err, dwell_err, err}, 0);
      check("clr_count", cycle_count, 0);
      check("clr_locked", locked, 1);

      // RED then GREEN is out of order.
      step(3'b100);
      check("jump_seq_err", seq_err, 1);
      check("jump_phase", phase, 2);
      check("jump_locked", locked, 1);
      check("jump_err", err, 1);
      check("jump_code_err", code_err, 0);

      // AMBER->RED coinciding with clear: count written as 1, old flag cleared.
      step(3'b010);
      check("amb_phase", phase, 3);
      step(3'b001, 1'b1);
      check("clrcnt_seq_err", seq_err, 0);
      check("clrcnt_count", cycle_count, 1);
      check("clrcnt_count_w2", cycle_count2, 1);
      repeat (15) step(3'b001);
      check("dwell16_err", dwell_err, 0);
      check("dwell16_any", err, 0);
      step(3'b001);
      check("dwell17_err", dwell_err, 1);
      check("dwell17_any", err, 1);
      check("dwell17_locked", locked, 1);

      // Clear on the same edge as an illegal code.
      step(3'b111, 1'b1);
      check("clrill_code_err", code_err, 1);
      check("clrill_seq_err", seq_err, 0);
      check("clrill_dwell_err", dwell_err, 0);
      check("clrill_err", err, 1);
      check("clrill_locked", locked, 0);
      check("clrill_phase", phase, 0);

      // Counter wrap with CNT_W=2.
      step(3'b001, 1'b1);
      check("wrap_start_w2", cycle_count2, 0);
      check("wrap_start_locked", locked2, 1);
      for (int k = 1; k <= 5; k++) begin
         step(3'b011);
         step(3'b100);
         step(3'b010);
         step(3'b001);
         check($sformatf("wrap_w2_%0d", k), cycle_count2, k % 4);
         check($sformatf("wrap_w8_%0d", k), cycle_count, k);
      end
      check("wrap_err", err, 0);

      // Reset mid-sequence discards the tracked phase.
      step(3'b011);
      step(3'b100);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_locked", locked, 0);
      check("midrst_phase", phase, 0);
      check("midrst_count", cycle_count, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(3'b011);
      check("postrst_locked", locked, 1);
      check("postrst_seq_err", seq_err, 0);
      check("postrst_phase", phase, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
